// File: rtl/arb_pkg.sv
// Shared types, sizes and helpers for the round-robin arbiter slice.
package arb_pkg;

  localparam int unsigned ARB_N   = 4;
  localparam int unsigned ARB_IDW = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // Rotate right so that requester 'amt' lands on bit 0 (highest priority).
  function automatic logic [ARB_N-1:0] rotr4(input logic [ARB_N-1:0]   vec,
                                             input logic [ARB_IDW-1:0] amt);
    logic [ARB_N-1:0] r;
    case (amt)
      2'd0:    r = vec;
      2'd1:    r = {vec[0], vec[3:1]};
      2'd2:    r = {vec[1:0], vec[3:2]};
      default: r = {vec[2:0], vec[3]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_4to2.sv
// 4-to-2 priority encoder: lowest set bit wins; idx=0, any=0 when nothing is set.
module prio_enc_4to2
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]   in,
  output logic [ARB_IDW-1:0] idx,
  output logic               any
);

  always_comb begin
    idx = '0;
    any = |in;
    if (in[0])      idx = 2'd0;
    else if (in[1]) idx = 2'd1;
    else if (in[2]) idx = 2'd2;
    else if (in[3]) idx = 2'd3;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with a bounded hold time per owner.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ARB_N-1:0]   req,
  output logic [ARB_N-1:0]   gnt,
  output logic [ARB_IDW-1:0] gnt_id,
  output logic               gnt_valid
);

  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e         state, state_n;
  logic [ARB_IDW-1:0] ptr, ptr_n;
  logic [HW-1:0]      hold_cnt, hold_n;
  logic [ARB_N-1:0]   gnt_n;
  logic [ARB_IDW-1:0] gnt_id_n;

  logic [ARB_IDW-1:0] base;
  logic [ARB_IDW-1:0] enc_idx;
  logic               enc_any;
  logic [ARB_IDW-1:0] win;

  // While busy the search starts just past the owner, so an expiring owner
  // that still requests naturally ranks last and wins only when alone.
  assign base = (state == ARB_BUSY) ? gnt_id + 2'd1 : ptr;

  prio_enc_4to2 u_enc (
    .in  (rotr4(req, base)),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign win       = enc_idx + base;
  assign gnt_valid = |gnt;

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    hold_n   = hold_cnt;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    case (state)
      ARB_IDLE: begin
        if (enc_any) begin
          state_n       = ARB_BUSY;
          gnt_n         = '0;
          gnt_n[win]    = 1'b1;
          gnt_id_n      = win;
          hold_n        = '0;
          ptr_n         = win + 2'd1;
        end
      end
      ARB_BUSY: begin
        if (req[gnt_id] && (hold_cnt < HOLD_LAST)) begin
          hold_n = hold_cnt + HW'(1);
        end else if (enc_any) begin
          gnt_n         = '0;
          gnt_n[win]    = 1'b1;
          gnt_id_n      = win;
          hold_n        = '0;
          ptr_n         = win + 2'd1;
        end else begin
          state_n = ARB_IDLE;
          gnt_n   = '0;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(req));
      assert ($onehot0(gnt));
      assert (gnt_valid == (|gnt));
      if (gnt_valid) assert (gnt[gnt_id]);
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with hand-computed expected grants.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input string tag, input logic [3:0] eg, input logic [1:0] eid);
    checks++;
    assert (gnt === eg) else begin
      errors++;
      $error("FAIL %s gnt=%b expected=%b", tag, gnt, eg);
    end
    checks++;
    assert (gnt_valid === (|eg)) else begin
      errors++;
      $error("FAIL %s gnt_valid=%b expected=%b", tag, gnt_valid, |eg);
    end
    if (eg != 4'b0000) begin
      checks++;
      assert (gnt_id === eid) else begin
        errors++;
        $error("FAIL %s gnt_id=%0d expected=%0d", tag, gnt_id, eid);
      end
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    rst = 1'b1;
    req = 4'b0000;
    step();
    step();
    expect_gnt("reset", 4'b0000, 2'd0);
    checks++;
    assert (gnt_id === 2'd0) else begin
      errors++;
      $error("FAIL reset_id gnt_id=%0d expected=0", gnt_id);
    end
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      expect_gnt("idle_no_req", 4'b0000, 2'd0);
    end

    // single request 0100, then drop
    req = 4'b0100;
    step();
    expect_gnt("single_grant", 4'b0100, 2'd2);
    step();
    expect_gnt("single_hold1", 4'b0100, 2'd2);
    step();
    expect_gnt("single_hold2", 4'b0100, 2'd2);
    req = 4'b0000;
    step();
    expect_gnt("single_drop", 4'b0000, 2'd0);

    // reset to put ptr back to 0, then full rotation with all requesting
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_gnt("reset2", 4'b0000, 2'd0);
    req = 4'b1111;
    step();
    for (int o = 0; o < 5; o++) begin
      exp_g = 4'b0001 << (o % 4);
      for (int k = 0; k < 8; k++) begin
        expect_gnt($sformatf("rotate_o%0d_k%0d", o, k), exp_g, 2'(o % 4));
        step();
      end
    end
    // last step above moved the grant from owner 0 to owner 1
    expect_gnt("rotate_to1", 4'b0010, 2'd1);

    // owner 1 holding with req=0011, then 1 drops: ptr 2 wraps to 0
    req = 4'b0011;
    step();
    expect_gnt("own1_hold", 4'b0010, 2'd1);
    req = 4'b0001;
    step();
    expect_gnt("wrap_to0", 4'b0001, 2'd0);

    // lone requester 3 held 20 cycles: re-granted without a gap
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      step();
      expect_gnt($sformatf("lone3_c%0d", c), 4'b1000, 2'd3);
    end

    // hand off to 1, then reset while 1 owns
    req = 4'b0010;
    step();
    expect_gnt("hand_to1", 4'b0010, 2'd1);
    rst = 1'b1;
    step();
    expect_gnt("rst_mid_grant", 4'b0000, 2'd0);
    rst = 1'b0;
    req = 4'b1010;
    step();
    expect_gnt("post_rst_first", 4'b0010, 2'd1);
    for (int k = 1; k < 8; k++) begin
      step();
      expect_gnt($sformatf("post_rst_hold%0d", k), 4'b0010, 2'd1);
    end
    step();
    expect_gnt("post_rst_next3", 4'b1000, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
